demux_1to2_buf: RTL and testbench

Buffered 1-to-2 demultiplexer stage with a valid/ready handshake: each accepted input word is steered by `sel` into one of two independent FIFOs, and each FIFO drains through its own output handshake. It sits directly downstream of the combinational 1-to-2 demux path and replaces its unregistered `o0`/`o1` outputs. Consumers on either channel can stall without losing data or blocking the other channel.

---
 rtl/demux_1to2_buf_if.sv | 32 +++
 rtl/demux_1to2_buf.sv | 57 +++++
 tb/tb_demux_1to2_buf.sv | 116 +++++++++++
 3 files changed

// File: rtl/demux_1to2_buf_if.sv
// demux_1to2_buf_if: handshake bundle for the buffered 1-to-2 demux.
//   i, sel, in_valid / in_ready       : input word, channel select and handshake
//   o0, o0_valid / o0_ready           : channel 0 head word and handshake
//   o1, o1_valid / o1_ready           : channel 1 head word and handshake
//   cnt0, cnt1                        : per-channel FIFO occupancy
//   master drives the input side and both consumer readies; slave is the demux.
interface demux_1to2_buf_if #(
    parameter int width = 2,
    parameter int depth = 4
);
    localparam int cw = $clog2(depth) + 1;
    logic [width-1:0] i;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] o0;
    logic             o0_valid;
    logic             o0_ready;
    logic [width-1:0] o1;
    logic             o1_valid;
    logic             o1_ready;
    logic [cw-1:0]    cnt0;
    logic [cw-1:0]    cnt1;
    modport master (
        output i, sel, in_valid, o0_ready, o1_ready,
        input  in_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1
    );
    modport slave (
        input  i, sel, in_valid, o0_ready, o1_ready,
        output in_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: steers each accepted input word by sel into one of two FIFOs.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears pointers and counts
//   bus   : demux_1to2_buf_if.slave (input handshake, two output channels, counts)
module demux_1to2_buf #(
    parameter int width = 2,
    parameter int depth = 4
) (
    input logic              clk,
    input logic              rst_n,
    demux_1to2_buf_if.slave  bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    logic [1:0]                  full;
    logic [1:0]                  ready;
    logic [1:0][cw-1:0]          cnt_v;
    logic [1:0][width-1:0]       head_v;
    assign ready = {bus.o1_ready, bus.o0_ready};
    // No full-bypass: a pop in the same cycle does not free a slot for the push.
    assign bus.in_ready = !full[bus.sel];
    for (genvar n = 0; n < 2; n++) begin : g_ch
        logic [width-1:0] mem [depth];
        logic [aw-1:0]    wp;
        logic [aw-1:0]    rp;
        logic [cw-1:0]    cnt;
        logic             valid;
        logic             push;
        logic             pop;
        assign full[n]   = cnt == cw'(depth);
        assign valid     = cnt != '0;
        assign push      = bus.in_valid && !full[n] && (bus.sel == 1'(n));
        assign pop       = valid && ready[n];
        // Head is masked so an empty channel presents zero rather than stale data.
        assign head_v[n] = valid ? mem[rp] : '0;
        assign cnt_v[n]  = cnt;
        always_ff @(posedge clk)
            if (push) mem[wp] <= bus.i;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                cnt <= cnt + cw'(push) - cw'(pop);
            end
        end
    end
    assign bus.o0       = head_v[0];
    assign bus.o1       = head_v[1];
    assign bus.o0_valid = cnt_v[0] != '0;
    assign bus.o1_valid = cnt_v[1] != '0;
    assign bus.cnt0     = cnt_v[0];
    assign bus.cnt1     = cnt_v[1];
endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf: vector table, directed corners and random traffic against a queue model.
module tb_demux_1to2_buf;
    logic clk = 0;
    logic rst_n = 0;
    int   passes = 0;
    int   total = 0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    demux_1to2_buf_if #(.width(2), .depth(4)) bus ();
    demux_1to2_buf #(.width(2), .depth(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic       s;
        logic       v;
        logic [1:0] d;
        logic       r0;
        logic       r1;
        logic       rdy;
        int         c0;
        int         c1;
        logic [1:0] o0;
        logic [1:0] o1;
    } vec_t;
    vec_t tv[15];
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic chk_model();
        chk("cnt0", int'(bus.cnt0), q0.size());
        chk("cnt1", int'(bus.cnt1), q1.size());
        chk("o0_valid", int'(bus.o0_valid), int'(q0.size() > 0));
        chk("o1_valid", int'(bus.o1_valid), int'(q1.size() > 0));
        chk("o0", int'(bus.o0), q0.size() > 0 ? int'(q0[0]) : 0);
        chk("o1", int'(bus.o1), q1.size() > 0 ? int'(q1[0]) : 0);
    endtask
    // Applies one cycle of stimulus; model decisions use pre-edge occupancy.
    task automatic step(input logic s, input logic v, input logic [1:0] d, input logic r0, input logic r1);
        bit push, pop0, pop1;
        bus.sel = s; bus.in_valid = v; bus.i = d; bus.o0_ready = r0; bus.o1_ready = r1;
        #1;
        push = v && ((s ? q1.size() : q0.size()) < 4);
        pop0 = r0 && q0.size() > 0;
        pop1 = r1 && q1.size() > 0;
        chk("in_ready", int'(bus.in_ready), int'((s ? q1.size() : q0.size()) < 4));
        @(posedge clk);
        #1;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (push) begin
            if (s) q1.push_back(d);
            else q0.push_back(d);
        end
        chk_model();
    endtask
    initial begin
        tv[0]  = '{0, 1, 2'b01, 0, 0, 1, 1, 0, 2'b01, 2'b00};
        tv[1]  = '{0, 1, 2'b10, 0, 0, 1, 2, 0, 2'b01, 2'b00};
        tv[2]  = '{0, 1, 2'b11, 0, 0, 1, 3, 0, 2'b01, 2'b00};
        tv[3]  = '{1, 1, 2'b00, 0, 0, 1, 3, 1, 2'b01, 2'b00};
        tv[4]  = '{1, 1, 2'b01, 0, 0, 1, 3, 2, 2'b01, 2'b00};
        tv[5]  = '{1, 1, 2'b10, 0, 0, 1, 3, 3, 2'b01, 2'b00};
        tv[6]  = '{1, 1, 2'b11, 0, 0, 1, 3, 4, 2'b01, 2'b00};
        tv[7]  = '{1, 1, 2'b00, 0, 0, 0, 3, 4, 2'b01, 2'b00};
        tv[8]  = '{0, 0, 2'b00, 0, 0, 1, 3, 4, 2'b01, 2'b00};
        tv[9]  = '{0, 0, 2'b00, 0, 1, 1, 3, 3, 2'b01, 2'b01};
        tv[10] = '{0, 0, 2'b00, 0, 1, 1, 3, 2, 2'b01, 2'b10};
        tv[11] = '{0, 0, 2'b00, 0, 1, 1, 3, 1, 2'b01, 2'b11};
        tv[12] = '{0, 0, 2'b00, 0, 1, 1, 3, 0, 2'b01, 2'b00};
        tv[13] = '{0, 1, 2'b00, 0, 0, 1, 4, 0, 2'b01, 2'b00};
        tv[14] = '{0, 1, 2'b11, 1, 0, 0, 3, 0, 2'b10, 2'b00};
        bus.i = 0; bus.sel = 0; bus.in_valid = 0; bus.o0_ready = 0; bus.o1_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk_model();
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 15; k++) begin
            bus.sel = tv[k].s;
            #1;
            chk($sformatf("tv%0d in_ready", k), int'(bus.in_ready), int'(tv[k].rdy));
            step(tv[k].s, tv[k].v, tv[k].d, tv[k].r0, tv[k].r1);
            chk($sformatf("tv%0d cnt0", k), int'(bus.cnt0), tv[k].c0);
            chk($sformatf("tv%0d cnt1", k), int'(bus.cnt1), tv[k].c1);
            chk($sformatf("tv%0d o0", k), int'(bus.o0), int'(tv[k].o0));
            chk($sformatf("tv%0d o1", k), int'(bus.o1), int'(tv[k].o1));
        end
        repeat (4) step(0, 0, 2'b00, 1, 1);
        for (int k = 0; k < 12; k++) begin
            step(1'(k % 2), 1, 2'(k / 2), 1, 1);
            chk("stream cnt<=1", int'(bus.cnt0 <= 1 && bus.cnt1 <= 1), 1);
        end
        step(0, 0, 2'b00, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 2'(k + 1), 0, 0);
        #3;
        rst_n = 0;
        #1;
        q0.delete();
        q1.delete();
        chk("async o0_valid", int'(bus.o0_valid), 0);
        chk("async cnt0", int'(bus.cnt0), 0);
        chk("async o0", int'(bus.o0), 0);
        chk("async in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        step(0, 1, 2'b10, 0, 0);
        chk("post reset o0", int'(bus.o0), 2);
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
